// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int CNT_W  = 5;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serialiser: register array, wrapping pointers
// and an occupancy count that drives full/empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push, do_pop;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; count and pointers decide which
  // entries are meaningful, so resetting the data would only cost flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised 8N1/8N2, LSB first, with
// each bit lasting OVERSAMPLE+1 baud ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 15,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_tick_i,
  input  logic              tx_en_i,
  input  logic [BYTE_W-1:0] t_data_i,
  input  logic              t_valid_i,
  output logic              t_ready_o,
  output logic              tx_o,
  output logic              t_busy_o,
  output logic              t_done_o
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_q, stop_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [BYTE_W-1:0] fifo_rdata;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (t_valid_i),
    .wdata (t_data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state registers use non-blocking assignments only; all next-state
  // arithmetic stays in the combinational process with blocking assignments.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      stop_q    <= 1'b0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // A disabled transmitter sees no ticks, so every counter below freezes.
  assign bit_end = tx_en_i && tx_tick_i && (cnt_q == BIT_LAST);

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    if (tx_en_i && tx_tick_i && state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en_i && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          tx_d     = 1'b0;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign t_ready_o = !fifo_full;
  assign tx_o      = tx_q;
  assign t_busy_o  = (state_q != IDLE);
  assign t_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: an 8N1 (OVERSAMPLE=3) and an 8N2 (OVERSAMPLE=15)
// instance, each checked every cycle against a tick-count line model.
module tb_uart_tx;

  localparam int DEPTH = 4;

  function automatic int os_of(input int g);
    return (g == 0) ? 3 : 15;
  endfunction

  function automatic int sb_of(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  function automatic int total_of(input int g);
    return (9 + sb_of(g)) * (os_of(g) + 1);
  endfunction

  // Line level during bit slot idx of a frame: start, 8 data LSB first, stop(s).
  function automatic logic level_of(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] tick  = '0;
  logic [1:0] en    = '0;
  logic [1:0] valid = '0;
  logic [7:0] data [2];
  logic [1:0] ready, tx, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.OVERSAMPLE(3), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tx_tick_i (tick[0]),
    .tx_en_i   (en[0]),
    .t_data_i  (data[0]),
    .t_valid_i (valid[0]),
    .t_ready_o (ready[0]),
    .tx_o      (tx[0]),
    .t_busy_o  (busy[0]),
    .t_done_o  (done[0])
  );

  uart_tx #(.OVERSAMPLE(15), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tx_tick_i (tick[1]),
    .tx_en_i   (en[1]),
    .t_data_i  (data[1]),
    .t_valid_i (valid[1]),
    .t_ready_o (ready[1]),
    .tx_o      (tx[1]),
    .t_busy_o  (busy[1]),
    .t_done_o  (done[1])
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Tick/enable driver. Modes: 0 every cycle, 1 every 4th cycle, 2 random.
  int tick_mode [2] = '{0, 1};
  bit en_req    [2] = '{0, 0};
  bit en_rand   [2] = '{0, 0};
  int ph        [2] = '{0, 0};

  always @(negedge clk_i) begin
    for (int g = 0; g < 2; g++) begin
      case (tick_mode[g])
        0: tick[g] = 1'b1;
        1: begin
          tick[g] = (ph[g] == 0);
          ph[g]   = (ph[g] + 1) % 4;
        end
        2:       tick[g] = 1'($urandom_range(0, 1));
        default: tick[g] = 1'b0;
      endcase
      en[g] = en_rand[g] ? ($urandom_range(0, 7) != 0) : en_req[g];
    end
  end

  // Reference model: byte queue plus, for the frame on the line, the byte and
  // the number of enabled ticks consumed since its start edge.
  logic [7:0] mq [2][$];
  bit         m_act  [2];
  int         m_n    [2];
  logic [7:0] m_cur  [2];
  bit         m_done [2];

  always @(posedge clk_i or negedge rst_i) begin
    for (int g = 0; g < 2; g++) begin
      bit acc;
      if (!rst_i) begin
        mq[g].delete();
        m_act[g]  = 1'b0;
        m_n[g]    = 0;
        m_done[g] = 1'b0;
      end else begin
        acc       = valid[g] && (mq[g].size() < DEPTH);
        m_done[g] = 1'b0;
        if (en[g]) begin
          if (!m_act[g]) begin
            if (mq[g].size() > 0) begin
              m_cur[g] = mq[g].pop_front();
              m_act[g] = 1'b1;
              m_n[g]   = 0;
            end
          end else if (tick[g]) begin
            m_n[g]++;
            if (m_n[g] == total_of(g)) begin
              m_act[g]  = 1'b0;
              m_done[g] = 1'b1;
            end
          end
        end
        if (acc) mq[g].push_back(data[g]);
      end
    end
  end

  // Per-cycle checker; also measures enabled ticks per frame independently.
  int ft       [2] = '{0, 0};
  bit busy_s   [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  always begin
    @(posedge clk_i);
    for (int g = 0; g < 2; g++) begin
      if (!busy_s[g]) ft[g] = 0;
      else if (tick[g] && en[g]) ft[g]++;
    end
    @(negedge clk_i);
    for (int g = 0; g < 2; g++) begin
      logic exp_tx;
      exp_tx = m_act[g] ? level_of(m_cur[g], m_n[g] / (os_of(g) + 1)) : 1'b1;
      check($sformatf("c%0d_tx", g), 32'(tx[g]), 32'(exp_tx));
      check($sformatf("c%0d_busy", g), 32'(busy[g]), 32'(m_act[g]));
      check($sformatf("c%0d_done", g), 32'(done[g]), 32'(m_done[g]));
      check($sformatf("c%0d_ready", g), 32'(ready[g]), 32'(mq[g].size() < DEPTH));
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        check($sformatf("c%0d_frame_ticks", g), 32'(ft[g]), 32'(total_of(g)));
      end
      busy_s[g] = (busy[g] === 1'b1);
    end
  end

  // Called at a negedge; holds the byte until the DUT takes it.
  task automatic push_byte(input int g, input logic [7:0] b);
    int w;
    w        = 0;
    data[g]  = b;
    valid[g] = 1'b1;
    while (!ready[g] && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    check($sformatf("c%0d_push_wait", g), 32'(w < 3000), 32'd1);
    @(negedge clk_i);
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    while ((mq[g].size() != 0 || m_act[g] || valid[g]) && k < 20000) begin
      @(negedge clk_i);
      k++;
    end
    check($sformatf("c%0d_idle_wait", g), 32'(k < 20000), 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int base;
    int k;
    data[0] = '0;
    data[1] = '0;

    repeat (3) @(negedge clk_i);
    check("rst_tx", 32'(tx), 32'b11);
    check("rst_busy", 32'(busy), 32'b00);
    check("rst_done", 32'(done), 32'b00);
    check("rst_ready", 32'(ready), 32'b11);
    rst_i     = 1'b1;
    en_req[0] = 1'b1;
    en_req[1] = 1'b1;

    // Single 8N1 frame.
    push_byte(0, 8'hA5);
    wait_idle(0);
    check("a5_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Back-to-back frames.
    base = done_cnt[0];
    push_byte(0, 8'h00);
    push_byte(0, 8'hFF);
    push_byte(0, 8'h3C);
    wait_idle(0);
    check("b2b_done_cnt", 32'(done_cnt[0] - base), 32'd3);

    // Fill with the transmitter disabled, hold a fifth byte, then drain.
    en_req[0] = 1'b0;
    repeat (2) @(negedge clk_i);
    base = done_cnt[0];
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    push_byte(0, 8'h33);
    check("ready_after_3", 32'(ready[0]), 32'd1);
    push_byte(0, 8'h44);
    check("ready_after_4", 32'(ready[0]), 32'd0);
    data[0]  = 8'h55;
    valid[0] = 1'b1;
    repeat (10) @(negedge clk_i);
    check("ready_held", 32'(ready[0]), 32'd0);
    check("busy_while_disabled", 32'(busy[0]), 32'd0);
    en_req[0] = 1'b1;
    push_byte(0, 8'h55);
    wait_idle(0);
    check("drain_done_cnt", 32'(done_cnt[0] - base), 32'd5);

    // 8N2 frame with a tick every 4 clocks.
    push_byte(1, 8'h81);
    wait_idle(1);
    check("n2_done_cnt", 32'(done_cnt[1]), 32'd1);

    // Enable dropped for 10 cycles in the middle of the data bits.
    base = done_cnt[0];
    push_byte(0, 8'h5A);
    repeat (9) @(negedge clk_i);
    en_req[0] = 1'b0;
    repeat (10) @(negedge clk_i);
    en_req[0] = 1'b1;
    wait_idle(0);
    check("pause_done_cnt", 32'(done_cnt[0] - base), 32'd1);

    // Random bytes, random ticks, random enable on both instances.
    tick_mode[0] = 2;
    en_rand[0]   = 1'b1;
    base = done_cnt[0];
    for (int i = 0; i < 24; i++) begin
      push_byte(0, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    wait_idle(0);
    check("rand0_done_cnt", 32'(done_cnt[0] - base), 32'd24);
    tick_mode[1] = 2;
    en_rand[1]   = 1'b1;
    base = done_cnt[1];
    for (int i = 0; i < 3; i++) push_byte(1, 8'($urandom));
    wait_idle(1);
    check("rand1_done_cnt", 32'(done_cnt[1] - base), 32'd3);

    // Reset during data bit 3 with two bytes still queued.
    tick_mode[0] = 0;
    en_rand[0]   = 1'b0;
    en_req[0]    = 1'b1;
    repeat (2) @(negedge clk_i);
    base = done_cnt[0];
    push_byte(0, 8'hC3);
    push_byte(0, 8'h12);
    push_byte(0, 8'h34);
    k = 0;
    while (!(m_act[0] && m_n[0] >= 17) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("reach_bit3", 32'(k < 200), 32'd1);
    check("bit3_level", 32'(tx[0]), 32'd0);
    #2 rst_i = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx[0]), 32'd1);
    check("rst_async_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (100) @(negedge clk_i);
    check("post_rst_done_cnt", 32'(done_cnt[0] - base), 32'd0);
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    check("post_rst_tx", 32'(tx[0]), 32'd1);
    check("post_rst_ready", 32'(ready[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit-side counterpart of the FPGA UART receiver, sharing its baud tick and oversample convention so both ends agree on bit length. Bytes arrive on a valid/ready handshake into a small FIFO and are serialised 8N1 or 8N2, LSB first, onto `tx_o`. It sits between the core's UART peripheral register logic and the board TX pin.

## Interface
- `OVERSAMPLE`, 15: bit period is OVERSAMPLE+1 ticks of `tx_tick_i`; legal range 0..31.
- `STOP_BITS`, 1: stop-bit count; legal values 1 or 2.
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, 2..16.
- `clk_i` in 1: single clock for the whole block.
- `rst_i` in 1: reset is asynchronous and active-low.
- `tx_tick_i` in 1: baud tick, one-cycle strobe from the shared baud generator.
- `tx_en_i` in 1: transmitter enable; low freezes the serialiser.
- `t_data_i` in 8: byte to transmit.
- `t_valid_i` in 1: `t_data_i` is valid.
- `t_ready_o` out 1: FIFO can accept a byte (FIFO not full).
- `tx_o` out 1: serial line, idle high, registered.
- `t_busy_o` out 1: serialiser not in IDLE.
- `t_done_o` out 1: one-cycle pulse when the last stop bit completes.

## Operation
- Push: on a clock edge with `t_valid_i && t_ready_o`, the byte is written to the FIFO. When `t_ready_o` is 0 the byte is not stored; the producer holds it. A full FIFO does not accept a push even if a pop occurs in the same cycle.
- States: IDLE, START, DATA, STOP. Tick counter `cnt` is 5 bits; bit counter `bit_cnt` is 3 bits; stop counter is 1 bit; shift register `shreg` is 8 bits.
- IDLE: `tx_o`=1. If `tx_en_i` and the FIFO is not empty, the block pops into `shreg` at the clock edge, drives `tx_o`=0, sets `cnt`=0, and moves to START. No tick is needed to leave IDLE.
- START, DATA, STOP: on each `tx_tick_i`, if `cnt`==OVERSAMPLE the bit ends and `cnt` becomes 0; otherwise `cnt` increments.
- End of START: `tx_o`=`shreg[0]`, `bit_cnt`=0, next state DATA.
- End of a DATA bit: `shreg` shifts right. If `bit_cnt`==7, `tx_o`=1 and the next state is STOP. Otherwise `bit_cnt` increments and `tx_o` takes the new `shreg[0]`.
- End of STOP: when STOP_BITS stop bits are complete, `t_done_o`=1 for one cycle and the next state is IDLE.
- Back-to-back transmission: if the FIFO is not empty, the block leaves IDLE on the next clock. The gap is exactly one clock with the line high, never a whole bit.
- `tx_en_i`=0: state, counters, `shreg` and `tx_o` hold, ticks are ignored, and no pop occurs. FIFO pushes still proceed.
- `tx_tick_i` together with `tx_en_i`=0 is ignored. A tick and a push in the same cycle are independent.

## Timing
- Reset values: `tx_o`=1, `t_busy_o`=0, `t_done_o`=0, `t_ready_o`=1. FIFO is empty, state is IDLE, all counters are 0.
- Reset asserted mid-frame aborts the frame. `tx_o` returns to 1 asynchronously and the FIFO is flushed.
- Push-to-start latency into an empty, idle block: push at edge N; FIFO not empty after N; pop and `tx_o` falls at edge N+1.
- Frame length: (1+8+STOP_BITS)×(OVERSAMPLE+1) ticks from the falling edge of the start bit to the `t_done_o` pulse.
- `t_ready_o` is combinational from the FIFO count: 0 only when the count equals FIFO_DEPTH.
- `t_busy_o` is high from the pop edge until the edge at which the state returns to IDLE.

## Structure
- Shared package `uart_pkg` holds the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the width constants CNT_W=5 and BYTE_W=8. The receiver moves onto the same constants.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with a FIFO_DEPTH-entry register array, wrap-around read and write pointers, and a count of width $clog2(FIFO_DEPTH)+1. It has push/pop/full/empty ports and the same asynchronous active-low reset.
- The serialiser FSM lives in `uart_tx`.

## Test plan
- OVERSAMPLE=3, STOP_BITS=1, tick every cycle; push 0xA5 → `tx_o` is 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles; `t_done_o` pulses once, 40 ticks after the start edge.
- Push 0x00, 0xFF, 0x3C back-to-back with FIFO_DEPTH=4 → three frames separated by exactly one idle-high clock; `t_done_o` pulses 3 times.
- `tx_en_i` low, push 5 bytes into FIFO_DEPTH=4 → `t_ready_o` falls after the 4th push; the 5th byte is held by the producer. Raising `tx_en_i` sends bytes 1..4 in order, after which the 5th is accepted.
- STOP_BITS=2, OVERSAMPLE=15, tick every 4 clocks; push 0x81 → stop level lasts 32 ticks; frame is 176 ticks.
- Drop `tx_en_i` for 10 cycles mid-DATA → `tx_o` holds its level; the bit completes with the correct total tick count after re-enable.
- Assert `rst_i` during bit 3 of a frame with 2 bytes queued → `tx_o`=1 immediately; after release the FIFO is empty and no frame is sent.
